// File: rtl/usb_readout_streamer.sv
// usb_readout_streamer: moves readout FIFO words into the USB endpoint FIFO per start/stop session.
// Optional USB_STREAMER_WORD_COUNT_EN enables the saturating SessionWordCount counter.
module usb_readout_streamer #(
  parameter int DATA_WIDTH     = 16,
  parameter int WORD_CNT_WIDTH = 32
) (
  input  logic                      Clk,
  input  logic                      SlaveDaq_ResetUsbStart_n,
  input  logic                      UsbStartStop,
  input  logic                      OnceEnd,
  input  logic [DATA_WIDTH-1:0]     DataFifoDout,
  input  logic                      DataFifoEmpty,
  output logic                      DataFifoRdEn,
  input  logic                      UsbFifoFull,
  output logic                      UsbFifoWrEn,
  output logic [DATA_WIDTH-1:0]     UsbFifoDin,
  output logic                      DataTransmitDone,
  output logic                      UsbFifoEmpty,
  output logic [WORD_CNT_WIDTH-1:0] SessionWordCount
);
  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} state_t;
  state_t r_state;
  logic [DATA_WIDTH-1:0] r_hold;
  logic r_hold_valid, r_rd_pending, r_once_pending, r_usb_empty;
  logic w_active, w_wr, w_rd, w_drained, w_once;
  assign w_active = (r_state == ARMED) || (r_state == DRAIN);
  assign w_wr = r_hold_valid && !UsbFifoFull;
  assign w_rd = w_active && !DataFifoEmpty && !r_rd_pending && (!r_hold_valid || w_wr);
  // Look one edge ahead so DONE lands right after the final write.
  assign w_drained = DataFifoEmpty && !r_rd_pending && (!r_hold_valid || w_wr);
  assign w_once = r_once_pending || OnceEnd;
  assign DataFifoRdEn = w_rd;
  assign UsbFifoWrEn = w_wr;
  assign UsbFifoDin = r_hold;
  assign DataTransmitDone = (r_state == DONE);
  assign UsbFifoEmpty = r_usb_empty;
  always_ff @(posedge Clk or negedge SlaveDaq_ResetUsbStart_n) begin
    if (!SlaveDaq_ResetUsbStart_n) begin
      r_state <= IDLE;
      r_hold <= '0;
      r_hold_valid <= 1'b0;
      r_rd_pending <= 1'b0;
      r_once_pending <= 1'b0;
      r_usb_empty <= 1'b1;
    end else begin
      r_rd_pending <= w_rd;
      r_usb_empty <= DataFifoEmpty && !r_rd_pending && !r_hold_valid && !w_rd;
      if (r_rd_pending) begin
        r_hold <= DataFifoDout;
        r_hold_valid <= 1'b1;
      end else if (w_wr) begin
        r_hold_valid <= 1'b0;
      end
      case (r_state)
        IDLE: r_state <= UsbStartStop ? ARMED : IDLE;
        ARMED: r_state <= (OnceEnd || !UsbStartStop) ? DRAIN : ARMED;
        DRAIN: begin
          if (OnceEnd) r_once_pending <= 1'b1;
          r_state <= w_drained ? DONE : DRAIN;
        end
        default: begin
          // An OnceEnd landing on top of an already pending one stays queued.
          r_once_pending <= r_once_pending && OnceEnd;
          r_state <= w_once ? DRAIN : (UsbStartStop ? ARMED : IDLE);
        end
      endcase
    end
  end
`ifdef USB_STREAMER_WORD_COUNT_EN
  logic [WORD_CNT_WIDTH-1:0] r_word_cnt;
  always_ff @(posedge Clk or negedge SlaveDaq_ResetUsbStart_n) begin
    if (!SlaveDaq_ResetUsbStart_n) r_word_cnt <= '0;
    else if (r_state == IDLE && UsbStartStop) r_word_cnt <= '0;
    else if (w_wr && !(&r_word_cnt)) r_word_cnt <= r_word_cnt + WORD_CNT_WIDTH'(1);
  end
  assign SessionWordCount = r_word_cnt;
`else
  assign SessionWordCount = '0;
`endif
endmodule

// File: tb/tb_usb_readout_streamer.sv
// tb_usb_readout_streamer: vector table, directed corner sequences and a randomized session checked against a word-order scoreboard.
module tb_usb_readout_streamer;
  typedef struct packed {
    logic st, on, fl;
    logic [2:0] np;
    logic rd, wr;
    logic [15:0] din;
    logic done, ue;
    logic [7:0] cnt;
  } vec_t;
`ifdef USB_STREAMER_WORD_COUNT_EN
  localparam bit WC = 1'b1;
`else
  localparam bit WC = 1'b0;
`endif
  logic Clk = 1'b0;
  logic rst_n = 1'b0;
  logic UsbStartStop = 1'b0, OnceEnd = 1'b0, UsbFifoFull = 1'b0;
  logic [15:0] DataFifoDout = '0;
  logic DataFifoEmpty;
  logic DataFifoRdEn, UsbFifoWrEn, DataTransmitDone, UsbFifoEmpty;
  logic [15:0] UsbFifoDin;
  logic [31:0] SessionWordCount;
  logic [15:0] mem [256];
  int wp = 0, rp = 0;
  logic flush = 1'b0;
  logic [15:0] nxt = 16'd1;
  logic [15:0] exp_q[$];
  int thr_q[$];
  int pass = 0, total = 0, cyc = 0, nwr = 0, ndone = 0, last_wr = 0, last_done = 0, npush = 0;
  vec_t tbl [20];
  usb_readout_streamer dut (
    .Clk(Clk), .SlaveDaq_ResetUsbStart_n(rst_n), .UsbStartStop(UsbStartStop), .OnceEnd(OnceEnd),
    .DataFifoDout(DataFifoDout), .DataFifoEmpty(DataFifoEmpty), .DataFifoRdEn(DataFifoRdEn),
    .UsbFifoFull(UsbFifoFull), .UsbFifoWrEn(UsbFifoWrEn), .UsbFifoDin(UsbFifoDin),
    .DataTransmitDone(DataTransmitDone), .UsbFifoEmpty(UsbFifoEmpty), .SessionWordCount(SessionWordCount)
  );
  always #5 Clk = ~Clk;
  assign DataFifoEmpty = (wp == rp);
  always @(posedge Clk) begin
    if (flush) rp <= wp;
    else if (DataFifoRdEn) begin
      DataFifoDout <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end
  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, a, e);
  endtask
  function automatic vec_t v(int st, int on, int fl, int np, int rd, int wr, int din, int done, int ue, int cnt);
    vec_t r;
    r.st = st != 0; r.on = on != 0; r.fl = fl != 0; r.np = 3'(np);
    r.rd = rd != 0; r.wr = wr != 0; r.din = 16'(din);
    r.done = done != 0; r.ue = ue != 0; r.cnt = 8'(cnt);
    return r;
  endfunction
  task automatic step(int st, int on, int fl, int np);
    @(negedge Clk);
    UsbStartStop = st != 0; OnceEnd = on != 0; UsbFifoFull = fl != 0;
    for (int i = 0; i < np; i++) begin
      mem[wp[7:0]] = nxt;
      exp_q.push_back(nxt);
      nxt++; wp++; npush++;
    end
    #3;
    cyc++;
    if (UsbFifoWrEn) begin
      chk("wr_has_data", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("wr_order", UsbFifoDin, exp_q.pop_front());
      nwr++; last_wr = cyc;
    end
    if (DataFifoRdEn) chk("rd_not_empty", DataFifoEmpty, 1'b0);
    if (DataTransmitDone) begin
      ndone++; last_done = cyc;
      if (thr_q.size() > 0) chk("done_after_data", nwr >= thr_q.pop_front(), 1'b1);
    end
  endtask
  initial begin
    int d0, w0, n, ons, pb, wb, sb, db, on_i, np_i, fl_i;
    logic any_rd;
    tbl[0]  = v(1,0,0,4, 0,0,0,0,1,0);
    tbl[1]  = v(1,0,0,0, 1,0,0,0,0,0);
    tbl[2]  = v(1,0,0,0, 0,0,0,0,0,0);
    tbl[3]  = v(1,0,0,0, 1,1,1,0,0,0);
    tbl[4]  = v(1,0,0,0, 0,0,0,0,0,1);
    tbl[5]  = v(1,0,0,0, 1,1,2,0,0,1);
    tbl[6]  = v(1,0,0,0, 0,0,0,0,0,2);
    tbl[7]  = v(1,0,0,0, 1,1,3,0,0,2);
    tbl[8]  = v(1,0,0,0, 0,0,0,0,0,3);
    tbl[9]  = v(1,0,0,0, 0,1,4,0,0,3);
    tbl[10] = v(1,0,0,0, 0,0,0,0,0,4);
    tbl[11] = v(1,1,0,3, 1,0,0,0,1,4);
    tbl[12] = v(1,0,0,0, 0,0,0,0,0,4);
    tbl[13] = v(1,0,0,0, 1,1,5,0,0,4);
    tbl[14] = v(1,0,0,0, 0,0,0,0,0,5);
    tbl[15] = v(1,0,0,0, 1,1,6,0,0,5);
    tbl[16] = v(1,0,0,0, 0,0,0,0,0,6);
    tbl[17] = v(1,0,0,0, 0,1,7,0,0,6);
    tbl[18] = v(1,0,0,0, 0,0,0,1,0,7);
    tbl[19] = v(1,0,0,0, 0,0,0,0,1,7);
    repeat (2) @(negedge Clk);
    #3;
    chk("rst_rden", DataFifoRdEn, 1'b0);
    chk("rst_wren", UsbFifoWrEn, 1'b0);
    chk("rst_din", UsbFifoDin, 16'h0);
    chk("rst_done", DataTransmitDone, 1'b0);
    chk("rst_usb_empty", UsbFifoEmpty, 1'b1);
    chk("rst_count", SessionWordCount, 32'h0);
    @(negedge Clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(int'(tbl[i].st), int'(tbl[i].on), int'(tbl[i].fl), int'(tbl[i].np));
      chk("tbl_rden", DataFifoRdEn, tbl[i].rd);
      chk("tbl_wren", UsbFifoWrEn, tbl[i].wr);
      if (tbl[i].wr) chk("tbl_din", UsbFifoDin, tbl[i].din);
      chk("tbl_done", DataTransmitDone, tbl[i].done);
      chk("tbl_usb_empty", UsbFifoEmpty, tbl[i].ue);
      chk("tbl_count", SessionWordCount, WC ? 32'(tbl[i].cnt) : 32'h0);
    end
    step(1,0,1,2);
    step(1,0,1,0);
    step(1,0,1,0);
    for (int i = 0; i < 10; i++) begin
      step(1,0,1,0);
      chk("stall", {DataFifoRdEn, UsbFifoWrEn, UsbFifoDin}, {2'b00, exp_q[0]});
    end
    w0 = nwr; n = 0;
    while (nwr < w0 + 2 && n < 20) begin step(1,0,0,0); n++; end
    chk("stall_release_writes", nwr - w0, 2);
    d0 = ndone; w0 = nwr;
    step(1,1,0,6);
    step(1,0,0,0);
    step(1,0,0,0);
    step(1,1,0,0);
    n = 0;
    while (ndone < d0 + 2 && n < 60) begin step(1,0,0,0); n++; end
    repeat (5) step(1,0,0,0);
    chk("two_once_dones", ndone - d0, 2);
    chk("two_once_writes", nwr - w0, 6);
    chk("done_after_last_wr", last_done > last_wr, 1'b1);
    d0 = ndone; w0 = nwr;
    step(1,0,0,2);
    step(0,0,0,0);
    n = 0;
    while (ndone < d0 + 1 && n < 30) begin step(0,0,0,0); n++; end
    repeat (3) step(0,0,0,0);
    chk("stop_dones", ndone - d0, 1);
    chk("stop_writes", nwr - w0, 2);
    any_rd = 1'b0;
    step(0,0,0,1);
    any_rd |= DataFifoRdEn;
    step(0,1,0,0);
    any_rd |= DataFifoRdEn;
    for (int i = 0; i < 3; i++) begin step(0,0,0,0); any_rd |= DataFifoRdEn; end
    chk("idle_no_read", any_rd, 1'b0);
    chk("idle_once_ignored", ndone - d0, 1);
    @(negedge Clk); flush = 1'b1;
    @(negedge Clk); flush = 1'b0;
    exp_q.delete();
    step(1,0,0,4);
    step(1,0,0,0);
    step(1,0,0,0);
    step(1,0,0,0);
    @(negedge Clk);
    rst_n = 1'b0; UsbStartStop = 1'b0;
    #3;
    chk("mid_rst_rden", DataFifoRdEn, 1'b0);
    chk("mid_rst_wren", UsbFifoWrEn, 1'b0);
    chk("mid_rst_din", UsbFifoDin, 16'h0);
    chk("mid_rst_done", DataTransmitDone, 1'b0);
    chk("mid_rst_usb_empty", UsbFifoEmpty, 1'b1);
    chk("mid_rst_count", SessionWordCount, 32'h0);
    @(negedge Clk); flush = 1'b1;
    @(negedge Clk); flush = 1'b0; rst_n = 1'b1;
    exp_q.delete();
    sb = nwr; db = ndone; pb = npush; wb = nwr; ons = 0;
    step(1,0,0,0);
    for (int i = 0; i < 800; i++) begin
      on_i = (ndone - db == ons && $urandom_range(0, 15) == 0) ? 1 : 0;
      np_i = ($urandom_range(0, 7) == 0 && (wp - rp) < 200) ? int'($urandom_range(1, 3)) : 0;
      fl_i = ($urandom_range(0, 4) == 0) ? 1 : 0;
      if (on_i != 0) begin thr_q.push_back(wb + npush + np_i - pb); ons++; end
      step(1, on_i, fl_i, np_i);
    end
    n = 0;
    while (ndone - db != ons && n < 300) begin step(1,0,0,0); n++; end
    thr_q.push_back(wb + npush - pb);
    ons++;
    step(1,1,0,0);
    n = 0;
    while ((ndone - db != ons || exp_q.size() != 0) && n < 2000) begin step(1,0,0,0); n++; end
    step(1,0,0,0);
    step(1,0,0,0);
    chk("rand_dones", ndone - db, ons);
    chk("rand_all_written", exp_q.size(), 0);
    chk("rand_usb_empty", UsbFifoEmpty, 1'b1);
    chk("rand_word_count", SessionWordCount, WC ? 32'(nwr - sb) : 32'h0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
